// File: rtl/dac_pkg.sv
// dac_pkg: shared types and helpers for the multi-channel PDM DAC.
// Stream FSM encoding keeps the FIFO read strobe on a single flop bit.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        LATCH = 2'b10
    } stream_state_t;

    localparam int UNDERRUN_W = 8;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_mod.sv
// pdm_mod: first-order delta-sigma modulator for one channel.
// The carry out of the phase accumulator is the registered PDM bit.
module pdm_mod #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty,
    output logic             pdm
);
    logic [WIDTH:0] acc_q;
    logic [WIDTH:0] acc_d;
    logic           pdm_q;

    // Add duty to the residue; the carry bit drops out next cycle.
    always_comb begin
        acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, duty};
    end

    // Accumulator and output flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= acc_q[WIDTH];
        end
    end

    assign pdm = pdm_q;

endmodule

// File: rtl/synchronizer.sv
// synchronizer: two-flop capture cell for asynchronous inputs.
// Reset clears both stages so a pending level is re-sampled afterwards.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops resolve metastability on the async input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pdm_dac_array.sv
// pdm_dac_array: multi-channel PDM DAC, each channel fed either by a
// CPU register (4-phase handshake) or by rate-paced FIFO samples.
module pdm_dac_array
    import dac_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 12,
    parameter int SAMPLE_DIV = 2500
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         src_sel,
    input  logic                        rv_req,
    input  logic [chan_w(CHANNELS)-1:0] rv_chan,
    input  logic [WIDTH-1:0]            rv_data,
    output logic                        rv_ack,
    input  logic [WIDTH*CHANNELS-1:0]   fifo_data,
    input  logic                        fifo_empty,
    output logic                        fifo_r_en,
    output logic [UNDERRUN_W-1:0]       underrun_cnt,
    output logic [CHANNELS-1:0]         pdm
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic                           req_s;
    logic [CHANNELS-1:0]            sel_s;
    logic                           ack_q;
    logic                           ack_d;
    logic [CHANNELS-1:0][WIDTH-1:0] rv_q;
    logic [CHANNELS-1:0][WIDTH-1:0] rv_d;
    logic [CHANNELS-1:0][WIDTH-1:0] stream_q;
    logic [CHANNELS-1:0][WIDTH-1:0] stream_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    stream_state_t                  state_q;
    stream_state_t                  state_d;
    logic [UNDERRUN_W-1:0]          und_q;
    logic [UNDERRUN_W-1:0]          und_d;
    logic                           tick;

    synchronizer #(.WIDTH(1)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rv_req),
        .q_o (req_s)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_sel_sync
        synchronizer #(.WIDTH(1)) u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (src_sel[c]),
            .q_o (sel_s[c])
        );
    end

    // Handshake: latch on synced req rise, release ack on its fall.
    always_comb begin
        ack_d = ack_q;
        rv_d  = rv_q;
        if (req_s && !ack_q) begin
            ack_d = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(rv_chan) == c) begin
                    rv_d[c] = rv_data;
                end
            end
        end else if (!req_s && ack_q) begin
            ack_d = 1'b0;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    // Sample pacing and stream FSM: read on tick, capture a cycle later.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        state_d  = state_q;
        und_d    = und_q;
        stream_d = stream_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        state_d = READ;
                    end else if (und_q != '1) begin
                        und_d = und_q + 1'b1;
                    end
                end
            end
            READ:  state_d = LATCH;
            LATCH: begin
                stream_d = fifo_data;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All control and sample state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            rv_q     <= '0;
            stream_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            und_q    <= '0;
        end else begin
            ack_q    <= ack_d;
            rv_q     <= rv_d;
            stream_q <= stream_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            und_q    <= und_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign duty[c] = sel_s[c] ? stream_q[c] : rv_q[c];

        pdm_mod #(.WIDTH(WIDTH)) u_mod (
            .clk  (clk),
            .rst  (rst),
            .duty (duty[c]),
            .pdm  (pdm[c])
        );
    end

    assign rv_ack       = ack_q;
    assign fifo_r_en    = state_q[0];
    assign underrun_cnt = und_q;

endmodule
